// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_ctrl_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 12;
  localparam int unsigned DEF_DEPTH  = 16;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    RESP
  } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin winner select (purely combinational).
//   valid0/valid1 : request valid per port
//   last_grant    : port granted on the previous accept
//   grant_c       : one-hot grant, zero when nobody requests
//   winner_c      : index of the winning port (PORT0 when idle)
module rr_arbiter2
  import mem_ctrl_pkg::*;
(
  input  logic       valid0,
  input  logic       valid1,
  input  logic       last_grant,
  output logic [1:0] grant_c,
  output logic       winner_c
);

  always_comb begin
    winner_c = PORT0;
    grant_c  = 2'b00;
    // On a tie the port not granted last time wins.
    if (valid0 && valid1) begin
      winner_c = ~last_grant;
    end else if (valid1) begin
      winner_c = PORT1;
    end
    if (valid0 || valid1) begin
      grant_c[winner_c] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin controller sharing a single-port registered memory between
// two requesters. One transaction in flight; responses on the granted port.
//   m*_req_*  : command channel (valid/ready, write, addr, wdata)
//   m*_rsp_*  : response channel (valid/ready, rdata, err)
//   mem_*     : memory pins; mem_reading is low only while a write issues
module mem_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req_valid,
  output logic              m0_req_ready,
  input  logic              m0_req_write,
  input  logic [ADDR_W-1:0] m0_req_addr,
  input  logic [DATA_W-1:0] m0_req_wdata,
  output logic              m0_rsp_valid,
  input  logic              m0_rsp_ready,
  output logic [DATA_W-1:0] m0_rsp_rdata,
  output logic              m0_rsp_err,
  input  logic              m1_req_valid,
  output logic              m1_req_ready,
  input  logic              m1_req_write,
  input  logic [ADDR_W-1:0] m1_req_addr,
  input  logic [DATA_W-1:0] m1_req_wdata,
  output logic              m1_rsp_valid,
  input  logic              m1_rsp_ready,
  output logic [DATA_W-1:0] m1_rsp_rdata,
  output logic              m1_rsp_err,
  output logic              mem_reading,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
);

  state_e                 state_q, state_d;
  logic                   last_q, last_d;
  logic                   write_q, write_d;
  logic                   reading_q, reading_d;
  logic [ADDR_W-1:0]      address_q, address_d;
  logic [DATA_W-1:0]      data_in_q, data_in_d;
  logic [1:0]             rsp_valid_q, rsp_valid_d;
  logic [1:0]             rsp_err_q, rsp_err_d;
  logic [1:0][DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  logic [1:0]        grant_c;
  logic              winner_c;
  logic              sel_write_c;
  logic [ADDR_W-1:0] sel_addr_c;
  logic [DATA_W-1:0] sel_wdata_c;
  logic              in_range_c;
  logic              rsp_ready_c;

  rr_arbiter2 u_arb (
    .valid0     (m0_req_valid),
    .valid1     (m1_req_valid),
    .last_grant (last_q),
    .grant_c    (grant_c),
    .winner_c   (winner_c)
  );

  // Winner's command and the granted port's response accept.
  assign sel_write_c = (winner_c == PORT1) ? m1_req_write : m0_req_write;
  assign sel_addr_c  = (winner_c == PORT1) ? m1_req_addr  : m0_req_addr;
  assign sel_wdata_c = (winner_c == PORT1) ? m1_req_wdata : m0_req_wdata;
  assign in_range_c  = sel_addr_c < ADDR_W'(DEPTH);
  assign rsp_ready_c = (last_q == PORT1) ? m1_rsp_ready : m0_rsp_ready;

  assign m0_req_ready = (state_q == IDLE) && grant_c[PORT0];
  assign m1_req_ready = (state_q == IDLE) && grant_c[PORT1];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= PORT1;
      write_q     <= 1'b0;
      reading_q   <= 1'b1;
      address_q   <= '0;
      data_in_q   <= '0;
      rsp_valid_q <= '0;
      rsp_err_q   <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      write_q     <= write_d;
      reading_q   <= reading_d;
      address_q   <= address_d;
      data_in_q   <= data_in_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    write_d     = write_q;
    reading_d   = reading_q;
    address_d   = address_q;
    data_in_d   = data_in_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;

    case (state_q)
      IDLE: begin
        if (|grant_c) begin
          last_d  = winner_c;
          write_d = sel_write_c;
          if (in_range_c) begin
            reading_d = ~sel_write_c;
            address_d = sel_addr_c;
            data_in_d = sel_wdata_c;
            state_d   = ISSUE;
          end else begin
            // Out-of-range: answer immediately, memory untouched.
            rsp_rdata_d           = '0;
            rsp_err_d             = '0;
            rsp_err_d[winner_c]   = 1'b1;
            rsp_valid_d[winner_c] = 1'b1;
            state_d               = RESP;
          end
        end
      end
      ISSUE: begin
        // Memory commits on this edge; never let a write linger.
        reading_d = 1'b1;
        state_d   = CAPTURE;
      end
      CAPTURE: begin
        rsp_rdata_d         = '0;
        rsp_rdata_d[last_q] = write_q ? '0 : mem_data_out;
        rsp_err_d           = '0;
        rsp_valid_d[last_q] = 1'b1;
        state_d             = RESP;
      end
      RESP: begin
        if (rsp_ready_c) begin
          rsp_valid_d = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_reading  = reading_q;
  assign mem_address  = address_q;
  assign mem_data_in  = data_in_q;
  assign m0_rsp_valid = rsp_valid_q[PORT0];
  assign m1_rsp_valid = rsp_valid_q[PORT1];
  assign m0_rsp_err   = rsp_err_q[PORT0];
  assign m1_rsp_err   = rsp_err_q[PORT1];
  assign m0_rsp_rdata = rsp_rdata_q[PORT0];
  assign m1_rsp_rdata = rsp_rdata_q[PORT1];

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter with a transaction-level reference model
// and a behavioural 16x32 registered memory.
module tb_mem_arbiter;

  typedef struct {
    bit          wr;
    int unsigned addr;
    logic [31:0] wdata;
  } req_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req_ready, m1_req_ready;
  logic        m0_rsp_valid, m1_rsp_valid;
  logic [31:0] m0_rsp_rdata, m1_rsp_rdata;
  logic        m0_rsp_err, m1_rsp_err;
  logic        mem_reading;
  logic [11:0] mem_address;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out = '0;
  logic [31:0] dev_mem [16];

  bit   pend [2];
  req_t cur [2];
  bit   rrdy [2];
  req_t rq [2][$];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [31:0] ref_mem [16];
  int          last = 1;
  bit          busy = 0;
  int          bport = 0;
  int          cnt = 0;
  int          lat = 0;
  logic [31:0] exp_rdata = '0;
  bit          exp_err = 0;
  bit          mem_low_exp = 0;
  int          acc_p = -1;
  bit          rsp_acc = 0;
  int          rsp_seen [2];
  int          hold_n = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .m0_req_valid (pend[0]),
    .m0_req_ready (m0_req_ready),
    .m0_req_write (cur[0].wr),
    .m0_req_addr  (12'(cur[0].addr)),
    .m0_req_wdata (cur[0].wdata),
    .m0_rsp_valid (m0_rsp_valid),
    .m0_rsp_ready (rrdy[0]),
    .m0_rsp_rdata (m0_rsp_rdata),
    .m0_rsp_err   (m0_rsp_err),
    .m1_req_valid (pend[1]),
    .m1_req_ready (m1_req_ready),
    .m1_req_write (cur[1].wr),
    .m1_req_addr  (12'(cur[1].addr)),
    .m1_req_wdata (cur[1].wdata),
    .m1_rsp_valid (m1_rsp_valid),
    .m1_rsp_ready (rrdy[1]),
    .m1_rsp_rdata (m1_rsp_rdata),
    .m1_rsp_err   (m1_rsp_err),
    .mem_reading  (mem_reading),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out)
  );

  // Single-port memory: writes on every edge where reading is low.
  always @(posedge clk) begin
    if (mem_reading) mem_data_out <= dev_mem[mem_address[3:0]];
    else             dev_mem[mem_address[3:0]] <= mem_data_in;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic req_t mk(input bit wr, input int unsigned addr, input logic [31:0] wd);
    req_t r;
    r.wr = wr; r.addr = addr; r.wdata = wd;
    return r;
  endfunction

  // One clock cycle: update model from last edge, check, then drive.
  task automatic step();
    bit exp_v;
    bit got_v;
    logic [31:0] got_d;
    bit got_e;
    int w;
    @(negedge clk);
    mem_low_exp = 0;
    if (rsp_acc) busy = 0;
    if (acc_p >= 0) begin
      busy = 1; bport = acc_p; cnt = 0;
      if (cur[acc_p].addr >= 16) begin
        lat = 1; exp_err = 1; exp_rdata = '0;
      end else begin
        lat = 3; exp_err = 0;
        if (cur[acc_p].wr) begin
          exp_rdata = '0;
          ref_mem[cur[acc_p].addr] = cur[acc_p].wdata;
          mem_low_exp = 1;
        end else begin
          exp_rdata = ref_mem[cur[acc_p].addr];
        end
      end
      pend[acc_p] = 0;
    end
    if (busy) cnt++;
    rsp_acc = 0;
    for (int p = 0; p < 2; p++) begin
      exp_v = busy && (bport == p) && (cnt >= lat);
      got_v = (p == 0) ? m0_rsp_valid : m1_rsp_valid;
      got_d = (p == 0) ? m0_rsp_rdata : m1_rsp_rdata;
      got_e = (p == 0) ? m0_rsp_err   : m1_rsp_err;
      check($sformatf("rsp_valid%0d", p), 32'(got_v), 32'(exp_v));
      if (exp_v) begin
        check($sformatf("rsp_rdata%0d", p), got_d, exp_rdata);
        check($sformatf("rsp_err%0d", p), 32'(got_e), 32'(exp_err));
        rsp_seen[p]++;
      end else begin
        rsp_seen[p] = 0;
      end
    end
    check("mem_reading", 32'(mem_reading), 32'(!mem_low_exp));
    for (int p = 0; p < 2; p++) begin
      if (!pend[p] && rq[p].size() > 0) begin
        cur[p] = rq[p].pop_front();
        pend[p] = 1;
      end
      rrdy[p] = (rsp_seen[p] > hold_n);
    end
    #1;
    w = -1;
    if (!busy) begin
      if (pend[0] && pend[1]) w = 1 - last;
      else if (pend[0])       w = 0;
      else if (pend[1])       w = 1;
    end
    check("req_ready0", 32'(m0_req_ready), 32'(w == 0));
    check("req_ready1", 32'(m1_req_ready), 32'(w == 1));
    acc_p = -1;
    if (pend[0] && m0_req_ready) acc_p = 0;
    else if (pend[1] && m1_req_ready) acc_p = 1;
    if (acc_p >= 0) last = acc_p;
    if (busy && cnt >= lat && rrdy[bport]) rsp_acc = 1;
  endtask

  task automatic drain();
    int n = 0;
    while ((busy || pend[0] || pend[1] || acc_p >= 0 ||
            rq[0].size() > 0 || rq[1].size() > 0) && n < 400) begin
      step();
      n++;
    end
    if (n >= 400) check("drain_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 16; i++) begin
      dev_mem[i] = 32'(i);
      ref_mem[i] = 32'(i);
    end
    for (int p = 0; p < 2; p++) begin
      pend[p] = 0; rrdy[p] = 0; rsp_seen[p] = 0;
      cur[p] = mk(0, 0, '0);
    end
    #12;
    // Reset values
    check("rst_mem_reading", 32'(mem_reading), 32'd1);
    check("rst_mem_address", 32'(mem_address), 32'd0);
    check("rst_mem_data_in", mem_data_in, 32'd0);
    check("rst_rsp", {28'd0, m0_rsp_valid, m1_rsp_valid, m0_rsp_err, m1_rsp_err}, 32'd0);
    check("rst_rdata", m0_rsp_rdata | m1_rsp_rdata, 32'd0);
    check("rst_ready", 32'({m0_req_ready, m1_req_ready}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Read, write/read-back, alternation, error path
    rq[0].push_back(mk(0, 5, '0));
    drain();
    rq[1].push_back(mk(1, 3, 32'hDEADBEEF));
    rq[1].push_back(mk(0, 3, '0));
    drain();
    for (int i = 0; i < 4; i++) begin
      rq[0].push_back(mk(0, 1, '0));
      rq[1].push_back(mk(0, 2, '0));
    end
    drain();
    rq[0].push_back(mk(0, 16, '0));
    rq[0].push_back(mk(1, 4095, 32'h12345678));
    rq[0].push_back(mk(0, 0, '0));
    drain();

    // Stalled response with a competing request
    hold_n = 5;
    rq[0].push_back(mk(0, 4, '0));
    rq[1].push_back(mk(0, 6, '0));
    drain();
    hold_n = 0;

    // Reset during ISSUE of a write: the write must be lost
    rq[0].push_back(mk(1, 7, 32'hCAFEF00D));
    n = 0;
    do begin
      step();
      n++;
    end while (acc_p != 0 && n < 20);
    check("reset_accept_seen", 32'(acc_p), 32'd0);
    @(negedge clk);
    check("issue_write_low", 32'(mem_reading), 32'd0);
    pend[0] = 0; pend[1] = 0;
    #1 rst_n = 1'b0;
    #1;
    check("arst_mem_reading", 32'(mem_reading), 32'd1);
    check("arst_mem_address", 32'(mem_address), 32'd0);
    check("arst_mem_data_in", mem_data_in, 32'd0);
    check("arst_rsp", {28'd0, m0_rsp_valid, m1_rsp_valid, m0_rsp_err, m1_rsp_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    busy = 0; last = 1; acc_p = -1; rsp_acc = 0;
    rsp_seen[0] = 0; rsp_seen[1] = 0; rrdy[0] = 0; rrdy[1] = 0;
    check("write_lost", dev_mem[7], ref_mem[7]);
    rq[0].push_back(mk(0, 7, '0));
    rq[1].push_back(mk(1, 7, 32'hA5A5A5A5));
    rq[0].push_back(mk(0, 7, '0));
    drain();

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (rq[p].size() == 0 && $urandom_range(0, 3) != 0)
          rq[p].push_back(mk(1'($urandom_range(0, 1)), $urandom_range(0, 19), $urandom()));
      end
      if ($urandom_range(0, 7) == 0) hold_n = $urandom_range(0, 3);
      step();
    end
    hold_n = 0;
    drain();

    for (int i = 0; i < 16; i++)
      check($sformatf("mem_word%0d", i), dev_mem[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
